lut_wave_player: RTL and testbench

Parametrised waveform playback engine for the wave-generator datapath. It is the successor to the fixed 1024×16 ECG lookup table. The LUT is loaded at run time through a write port instead of a file preload. A phase accumulator with a programmable fractional step walks the table in loop, one-shot or ping-pong mode. Samples stream out on a valid/ready handshake toward the DAC/filter stage.

---
 rtl/lut_wave_player.sv | 192 +++++++++++++++++++
 tb/tb_lut_wave_player.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_wave_player.sv
// lut_wave_player: run-time loaded LUT walked by a fractional phase accumulator.
// Define WAVE_GAIN_EN to add a saturating gain stage ahead of the output register.
module lut_wave_player #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 10,
   parameter int PHASE_W = 24,
   parameter int GAIN_W  = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wr_en,
   input  logic [ADDR_W-1:0]  i_wr_addr,
   input  logic [DATA_W-1:0]  i_wr_data,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [1:0]         i_mode,
   input  logic [PHASE_W-1:0] i_step,
   input  logic [GAIN_W-1:0]  i_gain,
   input  logic               i_ready,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_valid,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
   localparam logic [1:0] M_ONESHOT  = 2'b01;
   localparam logic [1:0] M_PINGPONG = 2'b10;

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d, step_q;
   logic [1:0]         mode_q;
   logic               dir_q, dir_d;
   logic               adv, flush, issue, borrow;
   logic [PHASE_W:0]   sum;
   logic [ADDR_W-1:0]  a1;
   logic               v1, v2, v_last, pipe_busy;
   logic [DATA_W-1:0]  rd_data, d_last;
   logic [DATA_W-1:0]  mem [2**ADDR_W];

   assign adv    = !o_valid || i_ready;
   assign flush  = i_stop && (state_q != S_IDLE);
   assign sum    = {1'b0, phase_q} + {1'b0, step_q};
   assign borrow = phase_q < step_q;
   assign o_busy = state_q != S_IDLE;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      dir_d   = dir_q;
      issue   = 1'b0;
      o_done  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_RUN;
               phase_d = '0;
               dir_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (adv) begin
               issue = 1'b1;
               unique case (mode_q)
                  M_ONESHOT: begin
                     if (sum[PHASE_W]) state_d = S_DRAIN;
                     else phase_d = sum[PHASE_W-1:0];
                  end
                  M_PINGPONG: begin
                     // dir_q high means the walk is heading down
                     if (!dir_q) begin
                        if (sum[PHASE_W]) begin
                           dir_d   = 1'b1;
                           phase_d = phase_q - step_q;
                        end else begin
                           phase_d = sum[PHASE_W-1:0];
                        end
                     end else if (borrow) begin
                        dir_d   = 1'b0;
                        phase_d = sum[PHASE_W-1:0];
                     end else begin
                        phase_d = phase_q - step_q;
                     end
                  end
                  default: phase_d = sum[PHASE_W-1:0];
               endcase
            end
         end
         S_DRAIN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (o_valid && i_ready && !pipe_busy) begin
               o_done  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         phase_q <= '0;
         dir_q   <= 1'b0;
         mode_q  <= '0;
         step_q  <= '0;
      end else begin
         phase_q <= phase_d;
         dir_q   <= dir_d;
         if (state_q == S_IDLE && i_start) begin
            mode_q <= i_mode;
            step_q <= i_step;
         end
      end
   end

   // read-first RAM; contents survive reset
   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      if (adv) rd_data <= mem[a1];
   end

`ifdef WAVE_GAIN_EN
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   logic signed [PROD_W-1:0] prod, scaled;
   logic [PROD_W-DATA_W:0]   top;
   logic [DATA_W-1:0]        g_data, g_sat;
   logic                     v3;

   assign prod = $signed({{(PROD_W-DATA_W){rd_data[DATA_W-1]}}, rd_data})
               * $signed({{DATA_W{1'b0}}, i_gain});
   assign scaled = prod >>> (GAIN_W-1);
   assign top    = scaled[PROD_W-1:DATA_W-1];

   always_comb begin
      g_sat = scaled[DATA_W-1:0];
      if (!(&top) && (|top))
         g_sat = scaled[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v3     <= 1'b0;
         g_data <= '0;
      end else if (flush) begin
         v3 <= 1'b0;
      end else if (adv) begin
         v3 <= v2;
         if (v2) g_data <= g_sat;
      end
   end

   assign v_last    = v3;
   assign d_last    = g_data;
   assign pipe_busy = v1 | v2 | v3;
`else
   logic unused_gain;
   assign unused_gain = ^i_gain;
   assign v_last      = v2;
   assign d_last      = rd_data;
   assign pipe_busy   = v1 | v2;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         a1      <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (flush) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         o_valid <= 1'b0;
      end else if (adv) begin
         v1      <= issue;
         v2      <= v1;
         o_valid <= v_last;
         if (issue) a1 <= phase_q[PHASE_W-1 -: ADDR_W];
         if (v_last) o_data <= d_last;
      end
   end

endmodule

// File: tb/tb_lut_wave_player.sv
// tb_lut_wave_player: randomized and directed playback checks against a
// behavioural phase-walk model of the wave player.
`timescale 1ns/1ps
module tb_lut_wave_player;
   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int PW    = 24;
   localparam int GW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam longint PMOD = 64'd1 << PW;
`ifdef WAVE_GAIN_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0, stop = 1'b0, ready = 1'b1;
   logic [1:0]    mode = '0;
   logic [PW-1:0] step = '0;
   logic [GW-1:0] gain = 8'd128;
   logic [DW-1:0] o_data;
   logic          o_valid, o_busy, o_done;

   lut_wave_player dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_mode(mode),
      .i_step(step), .i_gain(gain), .i_ready(ready), .o_data(o_data),
      .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [DW-1:0] lut_m [DEPTH];
   longint m_phase, m_step;
   bit     m_down, m_last;
   int     m_mode;

   function automatic void model_start(int md, longint st);
      m_mode = md; m_step = st; m_phase = 0; m_down = 0; m_last = 0;
   endfunction

   // returns the address of the next sample and walks the phase on
   function automatic int model_next();
      int a;
      a = int'(m_phase >> (PW - AW));
      if (m_mode == 1) begin
         if (m_phase + m_step >= PMOD) m_last = 1;
         else m_phase = m_phase + m_step;
      end else if (m_mode == 2) begin
         if (!m_down) begin
            if (m_phase + m_step >= PMOD) begin
               m_down = 1; m_phase = m_phase - m_step;
            end else m_phase = m_phase + m_step;
         end else begin
            if (m_phase < m_step) begin
               m_down = 0; m_phase = m_phase + m_step;
            end else m_phase = m_phase - m_step;
         end
      end else begin
         m_phase = (m_phase + m_step) % PMOD;
      end
      return a;
   endfunction

   task automatic write_word(int a, logic [DW-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      lut_m[a] = d;
   endtask

   task automatic load_ramp();
      for (int k = 0; k < DEPTH; k++) write_word(k, DW'(k));
      @(negedge clk); wr_en = 1'b0;
   endtask

   task automatic load_random();
      for (int k = 0; k < DEPTH; k++) write_word(k, DW'($urandom));
      @(negedge clk); wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b b=%b d=%b data=%h exp all 0",
                  o_valid, o_busy, o_done, o_data);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_loop();
      int first, n;
      load_ramp();
      @(negedge clk); mode = 2'b00; step = PW'(1 << 14); ready = 1'b1; start = 1'b1;
      first = -1; n = 0;
      for (int c = 1; c < 2200 && n < 2100; c++) begin
         @(negedge clk); start = 1'b0; #1;
         if (c == 1) begin
            checks++;
            if (o_busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b exp 1", o_busy); end
         end
         if (first >= 0) begin
            checks++;
            if (o_valid !== 1'b1) begin errors++; $display("FAIL loop_throughput cycle %0d valid %b exp 1", c, o_valid); end
         end
         if (o_valid === 1'b1) begin
            if (first < 0) begin
               first = c;
               checks++;
               if (c != LAT + 1) begin errors++; $display("FAIL loop_latency got %0d exp %0d", c, LAT + 1); end
            end
            checks++;
            if (o_data !== DW'(n % DEPTH)) begin
               errors++; $display("FAIL loop_data idx %0d got %h exp %h", n, o_data, DW'(n % DEPTH));
            end
            n++;
         end
      end
      checks++;
      if (n != 2100) begin errors++; $display("FAIL loop_count got %0d exp 2100", n); end
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0; #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL loop_stop got v=%b b=%b exp 0 0", o_valid, o_busy);
      end
   endtask

   task automatic test_oneshot();
      int n, dones;
      bit fin;
      @(negedge clk); mode = 2'b01; step = PW'(1 << 14); ready = 1'b1; start = 1'b1;
      n = 0; dones = 0; fin = 0;
      for (int c = 0; c < 1300 && !fin; c++) begin
         @(negedge clk); start = 1'b0; #1;
         if (o_done === 1'b1) begin
            dones++;
            checks++;
            if (o_valid !== 1'b1 || n != 1023) begin
               errors++; $display("FAIL oneshot_done_timing at sample %0d valid %b exp 1023 1", n, o_valid);
            end
         end
         if (o_valid === 1'b1) begin
            checks++;
            if (o_data !== DW'(n)) begin errors++; $display("FAIL oneshot_data idx %0d got %h exp %h", n, o_data, DW'(n)); end
            n++;
         end
         if (o_done === 1'b1) begin
            @(negedge clk); #1;
            checks++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
               errors++; $display("FAIL oneshot_after_done got b=%b v=%b exp 0 0", o_busy, o_valid);
            end
            fin = 1;
         end
      end
      checks++;
      if (!fin || n != 1024 || dones != 1) begin
         errors++; $display("FAIL oneshot_summary got fin=%0d n=%0d dones=%0d exp 1 1024 1", fin, n, dones);
      end
   endtask

   task automatic test_pingpong();
      int n;
      logic [DW-1:0] exp;
      @(negedge clk); mode = 2'b10; step = PW'(1 << 23); ready = 1'b1; start = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && n < 40; c++) begin
         @(negedge clk); start = 1'b0; #1;
         if (o_valid === 1'b1) begin
            exp = (n % 2 == 1) ? DW'(512) : DW'(0);
            checks++;
            if (o_data !== exp) begin errors++; $display("FAIL pingpong_data idx %0d got %h exp %h", n, o_data, exp); end
            n++;
         end
      end
      checks++;
      if (n != 40) begin errors++; $display("FAIL pingpong_count got %0d exp 40", n); end
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic test_stall();
      int n, stall_left, stalls;
      @(negedge clk); mode = 2'b00; step = PW'(1 << 14); ready = 1'b1; start = 1'b1;
      n = 0; stall_left = 0; stalls = 0;
      for (int c = 0; c < 400 && n < 100; c++) begin
         @(negedge clk); start = 1'b0; ready = (stall_left == 0); #1;
         if (stall_left > 0) begin
            stall_left--; stalls++;
            checks++;
            if (o_valid !== 1'b1 || o_data !== DW'(n % DEPTH)) begin
               errors++; $display("FAIL stall_hold got v=%b data=%h exp 1 %h", o_valid, o_data, DW'(n % DEPTH));
            end
         end else if (o_valid === 1'b1) begin
            checks++;
            if (o_data !== DW'(n % DEPTH)) begin
               errors++; $display("FAIL stall_data idx %0d got %h exp %h", n, o_data, DW'(n % DEPTH));
            end
            n++;
            if (n == 50) stall_left = 5;
         end
      end
      checks++;
      if (n != 100 || stalls != 5) begin errors++; $display("FAIL stall_count got n=%0d stalls=%0d exp 100 5", n, stalls); end
      @(negedge clk); ready = 1'b1; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic test_stop();
      @(negedge clk); mode = 2'b00; step = PW'(1 << 14); ready = 1'b1; start = 1'b1;
      repeat (20) begin @(negedge clk); start = 1'b0; end
      stop = 1'b1; start = 1'b1; #1;
      checks++;
      if (o_valid !== 1'b1 || o_done !== 1'b0) begin
         errors++; $display("FAIL stop_pre got v=%b d=%b exp 1 0", o_valid, o_done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); stop = 1'b0; start = 1'b0; #1;
         checks++;
         if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL stop_after cycle %0d got v=%b b=%b d=%b exp 0 0 0", c, o_valid, o_busy, o_done);
         end
      end
   endtask

   task automatic test_reset_mid();
      int first, n;
      @(negedge clk); mode = 2'b00; step = PW'(1 << 14); ready = 1'b1; start = 1'b1;
      repeat (20) begin @(negedge clk); start = 1'b0; end
      #1; rst = 1'b1; #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== '0) begin
         errors++; $display("FAIL reset_mid got v=%b b=%b d=%b data=%h exp all 0", o_valid, o_busy, o_done, o_data);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk); start = 1'b1;
      first = -1; n = 0;
      for (int c = 1; c < 20 && n < 2; c++) begin
         @(negedge clk); start = 1'b0; #1;
         if (o_valid === 1'b1) begin
            if (first < 0) begin
               first = c;
               checks++;
               if (c != LAT + 1) begin errors++; $display("FAIL restart_latency got %0d exp %0d", c, LAT + 1); end
            end
            checks++;
            if (o_data !== lut_m[n]) begin errors++; $display("FAIL restart_data idx %0d got %h exp %h", n, o_data, lut_m[n]); end
            n++;
         end
      end
      checks++;
      if (n != 2) begin errors++; $display("FAIL restart_count got %0d exp 2", n); end
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic test_random();
      logic [DW-1:0] nxt;
      bit have, nxt_last, prev_stall, fin, exp_done;
      int samples, md;
      longint st;
      load_random();
      for (int run = 0; run < 6; run++) begin
         md = $urandom_range(0, 3);
         st = (md == 1) ? longint'($urandom_range(1 << 16, (1 << 23) - 1))
                        : longint'($urandom_range(1, (1 << 23) - 1));
         model_start(md, st);
         have = 0; nxt_last = 0; prev_stall = 0; fin = 0; samples = 0; nxt = '0;
         @(negedge clk); mode = 2'(md); step = PW'(st); ready = 1'b1; start = 1'b1;
         for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 15) == 0);
            ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
               checks++;
               if (o_valid !== 1'b1) begin errors++; $display("FAIL rand_stall_valid run %0d got %b exp 1", run, o_valid); end
            end
            exp_done = 1'b0;
            if (o_valid === 1'b1) begin
               if (!have) begin
                  nxt = lut_m[model_next()]; nxt_last = m_last; have = 1;
               end
               checks++;
               if (o_data !== nxt) begin
                  errors++; $display("FAIL rand_data run %0d idx %0d got %h exp %h", run, samples, o_data, nxt);
               end
               exp_done = ready && nxt_last;
            end
            checks++;
            if (o_done !== exp_done) begin
               errors++; $display("FAIL rand_done run %0d idx %0d got %b exp %b", run, samples, o_done, exp_done);
            end
            prev_stall = (o_valid === 1'b1) && !ready;
            if (o_valid === 1'b1 && ready) begin
               have = 0; samples++;
               if (nxt_last || (md != 1 && samples >= 150)) fin = 1;
            end
         end
         checks++;
         if (!fin) begin errors++; $display("FAIL rand_timeout run %0d samples %0d exp completion", run, samples); end
         @(negedge clk); start = 1'b0; ready = 1'b1;
         if (md != 1) begin
            stop = 1'b1;
            @(negedge clk); stop = 1'b0;
         end
         #1;
         checks++;
         if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL rand_end run %0d got b=%b v=%b exp 0 0", run, o_busy, o_valid);
         end
      end
   endtask

`ifdef WAVE_GAIN_EN
   task automatic test_gain();
      logic [DW-1:0] exp [4];
      int n;
      bit fin;
      exp[0] = 16'h7F80; exp[1] = 16'h7FFF; exp[2] = 16'h8000; exp[3] = 16'h8080;
      write_word(0, 16'h4000); write_word(256, 16'h6000);
      write_word(512, 16'h8000); write_word(768, 16'hC000);
      @(negedge clk); wr_en = 1'b0; gain = 8'd255;
      mode = 2'b01; step = PW'(1 << 22); ready = 1'b1; start = 1'b1;
      n = 0; fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk); start = 1'b0; #1;
         if (o_valid === 1'b1 && n < 4) begin
            checks++;
            if (o_data !== exp[n]) begin errors++; $display("FAIL gain_data idx %0d got %h exp %h", n, o_data, exp[n]); end
            n++;
         end
         if (o_done === 1'b1) fin = 1;
      end
      checks++;
      if (!fin || n != 4) begin errors++; $display("FAIL gain_count got fin=%0d n=%0d exp 1 4", fin, n); end
      @(negedge clk); gain = 8'd128;
   endtask
`endif

   initial begin
      test_reset();
      test_loop();
      test_oneshot();
      test_pingpong();
      test_stall();
      test_stop();
      test_reset_mid();
      test_random();
`ifdef WAVE_GAIN_EN
      test_gain();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
